// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the funct encodings, the FSM state encoding and the default
// operand width. Also provides a helper that flags every funct the unit
// owns, which is the set that can stall while the unit is busy.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // MF*, MT*, MULT*, DIV*: everything that touches HI/LO or the datapath.
  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f inside {[FUNCT_MFHI:FUNCT_MTLO], [FUNCT_MULT:FUNCT_DIVU]});
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle for the multiply/divide unit.
//   master: pipeline side, drives the EX instruction (valid, funct, rs, rt)
//           and consumes stall_req, mf_data, busy, hi, lo.
//   slave : the unit itself.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [5:0]      ex_funct;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic            stall_req;
  logic [XLEN-1:0] mf_data;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output ex_valid, ex_funct, ex_rs_data, ex_rt_data,
    input  stall_req, mf_data, busy, hi, lo
  );

  modport slave (
    input  ex_valid, ex_funct, ex_rs_data, ex_rt_data,
    output stall_req, mf_data, busy, hi, lo
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operand magnitudes a, b and clear the counter
//   step       : perform one iteration (multiply or divide per is_div)
//   is_div     : selects the divide step
//   a, b       : multiply: a = multiplier, b = multiplicand
//                divide  : a = dividend,   b = divisor
//   acc        : {hi, lo}; after ITERS steps holds the product, or
//                {remainder, quotient} for a divide
//   last       : current step is the final one
module mdu_iter_core #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);
  localparam int CW = $clog2(ITERS) + 1;

  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc_nxt;

  // Multiply: add multiplicand into the upper half when the LSB is set,
  // then shift the whole thing (carry included) right by one.
  logic [XLEN:0]     mul_sum;
  // Divide: shift left, trial-subtract the divisor from the upper half
  // (kept one bit wider so the shifted-out MSB is not lost).
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    div_top  = acc[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
    if (is_div)
      acc_nxt = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]),
                 acc[XLEN-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  assign last = (count == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      b_q   <= '0;
      count <= '0;
    end else if (start) begin
      acc   <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      count <= '0;
    end else if (step) begin
      acc   <= acc_nxt;
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with architectural HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : ex_valid/ex_funct/ex_rs_data/ex_rt_data in from ID/EX;
//                stall_req to the hazard unit, mf_data to the EX result
//                mux, busy, and the current hi/lo out.
// Signed operations run on magnitudes; signs are reapplied in FIX.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave bus
);
  mdu_state_e      state;
  logic            busy_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            op_div_q;   // FIX needs to know which result format
  logic            neg_q_q;    // product / quotient gets negated
  logic            neg_r_q;    // remainder gets negated (dividend sign)
  logic            dz_q;       // divide by zero: LO forced to all ones

  logic [5:0]      f;
  logic            is_mul, is_div, is_signed, start;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [2*XLEN-1:0] core_acc;
  logic              core_last;
  logic              core_step;

  assign f         = bus.ex_funct;
  assign is_mul    = (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  assign is_div    = (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  assign is_signed = (f == FUNCT_MULT) || (f == FUNCT_DIV);
  assign start     = bus.ex_valid && !busy_q && (is_mul || is_div);
  assign rs_neg    = is_signed && bus.ex_rs_data[XLEN-1];
  assign rt_neg    = is_signed && bus.ex_rt_data[XLEN-1];
  assign a_mag     = rs_neg ? -bus.ex_rs_data : bus.ex_rs_data;
  assign b_mag     = rt_neg ? -bus.ex_rt_data : bus.ex_rt_data;
  assign core_step = (state == ST_MUL) || (state == ST_DIV);

  mdu_iter_core #(.XLEN(XLEN), .ITERS(ITERS)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .step   (core_step),
    .is_div (state == ST_DIV),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (core_acc),
    .last   (core_last)
  );

  // Sign-corrected results, consumed only on the FIX edge.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q_q ? -core_acc : core_acc;
    quo_fix  = dz_q ? '1 : (neg_q_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0]);
    rem_fix  = neg_r_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= is_div ? ST_DIV : ST_MUL;
            busy_q   <= 1'b1;
            op_div_q <= is_div;
            neg_q_q  <= rs_neg ^ rt_neg;
            neg_r_q  <= rs_neg;
            dz_q     <= is_div && (bus.ex_rt_data == '0);
          end else if (bus.ex_valid && f == FUNCT_MTHI) begin
            hi_q <= bus.ex_rs_data;
          end else if (bus.ex_valid && f == FUNCT_MTLO) begin
            lo_q <= bus.ex_rs_data;
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Unrelated instructions flow past a busy unit; only our own functs wait.
  assign bus.stall_req = bus.ex_valid && busy_q && is_mdu_funct(f);

  always_comb begin
    bus.mf_data = '0;
    if (bus.ex_valid && !busy_q) begin
      if (f == FUNCT_MFHI)      bus.mf_data = hi_q;
      else if (f == FUNCT_MFLO) bus.mf_data = lo_q;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a HI/LO scoreboard.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) bus();

  ex_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sa, sbv;
    res_t        r;
    p = '0;
    case (f)
      FUNCT_MULT:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      FUNCT_MULTU: p = {32'h0, a} * {32'h0, b};
      FUNCT_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else begin
          sa  = a;
          sbv = b;
          p = {32'(sa % sbv), 32'(sa / sbv)};
        end
      end
      FUNCT_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid   = v;
    bus.ex_funct   = f;
    bus.ex_rs_data = a;
    bus.ex_rt_data = b;
  endtask

  // Issue a MULT*/DIV* for one cycle, then leave a bubble in EX.
  task automatic start_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit push);
    drive(1'b1, f, a, b);
    #1;
    chk({tag, " start_no_stall"}, 32'(bus.stall_req), 32'd0);
    if (push) sb.push_back(model(f, a, b));
    tick();
    drive(1'b0, 6'h00, '0, '0);
    chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " hi"}, bus.hi, e.hi);
      chk({tag, " lo"}, bus.lo, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(exp_cycles));
    pop_check(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    drive(1'b0, 6'h00, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset stall", 32'(bus.stall_req), 32'd0);

    // Directed multiply / divide cases, including both wrap corners.
    start_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFF, 32'h2, 1'b1);
    wait_done("mult_neg", 33);
    chk("mult_neg const_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg const_lo", bus.lo, 32'hFFFF_FFFE);
    start_op("multu", FUNCT_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1);
    wait_done("multu", 33);
    chk("multu const_hi", bus.hi, 32'h0000_0001);
    start_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_done("div_neg", 33);
    chk("div_neg const_lo", bus.lo, 32'hFFFF_FFFD);
    start_op("divu_zero", FUNCT_DIVU, 32'd100, 32'd0, 1'b1);
    wait_done("divu_zero", 33);
    chk("divu_zero const_hi", bus.hi, 32'd100);
    start_op("div_zero_neg", FUNCT_DIV, 32'hFFFF_FF00, 32'd0, 1'b1);
    wait_done("div_zero_neg", 33);
    start_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf", 33);
    chk("div_ovf const_lo", bus.lo, 32'h8000_0000);

    // A few random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      rf = FUNCT_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 20)) : $urandom);
      start_op("rand", rf, ra, rb, 1'b1);
      wait_done("rand", 33);
    end

    // MFLO right behind a MULT stalls until the result lands.
    start_op("mflo_stall", FUNCT_MULT, 32'd3, 32'd5, 1'b1);
    drive(1'b1, FUNCT_MFLO, '0, '0);
    #1;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("mflo_stall cycles", 32'(n), 32'd33);
    chk("mflo_stall mf_data", bus.mf_data, 32'd15);
    chk("mflo_stall released", 32'(bus.stall_req), 32'd0);
    pop_check("mflo_stall");
    drive(1'b0, 6'h00, '0, '0);
    tick();

    // Unrelated instruction flows past; MF*/MT* wait while busy.
    start_op("add_behind", FUNCT_MULTU, 32'd7, 32'd6, 1'b1);
    drive(1'b1, 6'h20, 32'h1, 32'h2);
    #1;
    chk("add_behind stall", 32'(bus.stall_req), 32'd0);
    tick();
    drive(1'b1, FUNCT_MFHI, '0, '0);
    #1;
    chk("mfhi_busy stall", 32'(bus.stall_req), 32'd1);
    chk("mfhi_busy mf_data", bus.mf_data, 32'd0);
    drive(1'b1, FUNCT_MTLO, 32'hDEAD_BEEF, '0);
    #1;
    chk("mtlo_busy stall", 32'(bus.stall_req), 32'd1);
    drive(1'b0, 6'h00, '0, '0);
    wait_done("add_behind", 32);

    // MTHI/MTLO when idle, with an immediate MF* read.
    drive(1'b1, FUNCT_MTHI, 32'h1234, '0);
    #1;
    chk("mthi stall", 32'(bus.stall_req), 32'd0);
    tick();
    m_hi = 32'h1234;
    chk("mthi hi", bus.hi, m_hi);
    chk("mthi lo_kept", bus.lo, m_lo);
    drive(1'b1, FUNCT_MFHI, '0, '0);
    #1;
    chk("mfhi mf_data", bus.mf_data, 32'h1234);
    chk("mfhi stall", 32'(bus.stall_req), 32'd0);
    drive(1'b1, FUNCT_MTLO, 32'h0000_ABCD, '0);
    tick();
    m_lo = 32'h0000_ABCD;
    chk("mtlo lo", bus.lo, m_lo);
    chk("mtlo hi_kept", bus.hi, m_hi);
    drive(1'b1, FUNCT_MFLO, '0, '0);
    #1;
    chk("mflo mf_data", bus.mf_data, m_lo);
    drive(1'b0, FUNCT_MFLO, '0, '0);
    #1;
    chk("mflo bubble mf_data", bus.mf_data, 32'd0);

    // Reset in the middle of a divide discards it.
    start_op("div_rst", FUNCT_DIV, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("div_rst busy", 32'(bus.busy), 32'd0);
    chk("div_rst hi", bus.hi, 32'd0);
    chk("div_rst lo", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    start_op("mult_after_rst", FUNCT_MULT, 32'd2, 32'd2, 1'b1);
    wait_done("mult_after_rst", 33);
    chk("mult_after_rst const_lo", bus.lo, 32'd4);

    // A bubble carrying a MULT funct does nothing.
    drive(1'b0, FUNCT_MULT, 32'd5, 32'd5);
    #1;
    chk("bubble stall", 32'(bus.stall_req), 32'd0);
    tick();
    chk("bubble busy", 32'(bus.busy), 32'd0);
    chk("bubble hi", bus.hi, m_hi);
    chk("bubble lo", bus.lo, m_lo);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
